// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide execute unit with rd writeback.
module ex_muldiv #(
  parameter int unsigned XLEN          = 32,
  parameter bit          MUL_ITER      = 1'b1,
  parameter bit          DIV_EARLY_OUT = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_reg1_data,
  input  logic [XLEN-1:0] i_reg2_data,
  input  logic [4:0]      i_regd_addr,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_hold_flag,
  output logic            o_regd_we,
  output logic [4:0]      o_regd_w_addr,
  output logic [XLEN-1:0] o_regd_w_data
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned DW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched operation context
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            s1_q;
  logic            s2_q;
  logic            dz_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [CW-1:0]   cnt_q;

  // Writeback registers
  logic            we_q;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;

  // Acceptance-time decode
  logic            in_s1;
  logic            in_s2;
  logic            in_dz;
  logic            in_ovf;
  logic            in_single;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [DW-1:0]   prod_c;
  logic [XLEN-1:0] direct_hi;
  logic [XLEN-1:0] direct_lo;
  logic [XLEN-1:0] direct_res;

  // Iteration datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_rs;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;
  logic [XLEN-1:0] iter_res;

  // FSM control strobes
  logic accept;
  logic finish;

  // Applies operand signs to the magnitude result and selects the written half.
  // hi/lo hold the product for multiplies, remainder/quotient for divides.
  function automatic logic [XLEN-1:0] shape_result(
    input logic [2:0]      op,
    input logic            s1,
    input logic            s2,
    input logic            dz,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo
  );
    logic [DW-1:0]   prod;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] res;
    prod = {hi, lo};
    if (s1 ^ s2) prod = -prod;
    quot = (s1 ^ s2) ? -lo : lo;
    rem  = s1 ? -hi : hi;
    // Divide by zero returns all ones regardless of the dividend sign
    if (dz) quot = '1;
    if (!op[2]) begin
      res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[DW-1:XLEN];
    end else begin
      res = op[1] ? rem : quot;
    end
    return res;
  endfunction

  // Operand signs, magnitudes and special-case detection for the incoming op
  always_comb begin
    in_s1  = ((i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) ||
              (i_op == OP_REM)) && i_reg1_data[XLEN-1];
    in_s2  = ((i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM)) &&
             i_reg2_data[XLEN-1];
    mag1   = in_s1 ? -i_reg1_data : i_reg1_data;
    mag2   = in_s2 ? -i_reg2_data : i_reg2_data;
    in_dz  = i_op[2] && (i_reg2_data == '0);
    in_ovf = i_op[2] && !i_op[0] &&
             (i_reg1_data == {1'b1, {(XLEN-1){1'b0}}}) && (i_reg2_data == '1);
    if (!i_op[2]) begin
      in_single = !MUL_ITER;
    end else begin
      in_single = DIV_EARLY_OUT && (in_dz || in_ovf);
    end
  end

  // Single-cycle result: full product or the defined divide special cases
  always_comb begin
    prod_c    = '0;
    direct_hi = '0;
    direct_lo = '0;
    if (!MUL_ITER) prod_c = DW'(mag1) * DW'(mag2);
    if (!i_op[2]) begin
      {direct_hi, direct_lo} = prod_c;
    end else if (in_dz) begin
      // Remainder is the dividend; quotient is forced in shape_result
      direct_hi = mag1;
    end else begin
      // Overflow: magnitude quotient is 2^(XLEN-1), remainder zero
      direct_lo = mag1;
    end
    direct_res = shape_result(i_op, in_s1, in_s2, in_dz, direct_hi, direct_lo);
  end

  // One shift-add or one restoring-divide step on the {hi, lo} pair
  always_comb begin
    step_hi  = hi_q;
    step_lo  = lo_q;
    mul_sum  = '0;
    div_rs   = '0;
    div_diff = '0;
    if (!op_q[2]) begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      {step_hi, step_lo} = {mul_sum, lo_q[XLEN-1:1]};
    end else begin
      div_rs   = {hi_q, lo_q[XLEN-1]};
      div_diff = div_rs - {1'b0, mcand_q};
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_rs[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end
    iter_res = shape_result(op_q, s1_q, s2_q, dz_q, step_hi, step_lo);
  end

  // Next-state and control strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = in_single ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(XLEN - 1)) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation context capture and per-cycle iteration
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      op_q    <= '0;
      rd_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      op_q    <= i_op;
      rd_q    <= i_regd_addr;
      s1_q    <= in_s1;
      s2_q    <= in_s2;
      dz_q    <= in_dz;
      mcand_q <= i_op[2] ? mag2 : mag1;
      hi_q    <= '0;
      lo_q    <= i_op[2] ? mag1 : mag2;
      cnt_q   <= '0;
    end else if ((state_q == S_CALC) && !finish) begin
      hi_q    <= step_hi;
      lo_q    <= step_lo;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Writeback pulse; address and data hold their last values otherwise
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept && in_single) begin
        we_q    <= (i_regd_addr != 5'd0);
        waddr_q <= i_regd_addr;
        wdata_q <= direct_res;
      end else if (finish) begin
        we_q    <= (rd_q != 5'd0);
        waddr_q <= rd_q;
        wdata_q <= iter_res;
      end
    end
  end

  // Stall covers the request cycle and all iterations; fetch resumes in DONE
  assign o_hold_flag   = ((state_q == S_IDLE) && i_start) || (state_q == S_CALC);
  assign o_busy        = (state_q != S_IDLE);
  assign o_regd_we     = we_q;
  assign o_regd_w_addr = waddr_q;
  assign o_regd_w_data = wdata_q;

endmodule
